// File: rtl/psum_accum_pkg.sv
// Shared accelerator constants for the PSUM path.
// PSUM_DATA_W / PSUM_ROWS_LOG2 are the same constants that size the PSUM
// buffer, so the accumulator and buffer always agree on geometry.
package psum_accum_pkg;
  localparam int PSUM_DATA_W    = 32;
  localparam int PSUM_ROWS_LOG2 = 8;
  localparam int PSUM_ROWS      = 1 << PSUM_ROWS_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } psum_state_e;
endpackage

// File: rtl/psum_sat_add.sv
// Combinational signed add with optional saturation.
//   a_i, b_i : signed operands (DATA_W)
//   sum_o    : result, clamped to the signed range when SAT_EN=1, else wrapped
//   ovf_o    : 1 when the result was clamped (never set when SAT_EN=0)
module psum_sat_add #(
  parameter int DATA_W = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              ovf_o
);
  logic [DATA_W:0] wide;

  always_comb begin
    wide  = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};
    // Overflow iff the extra sign bit disagrees with the result's sign bit.
    ovf_o = SAT_EN && (wide[DATA_W] != wide[DATA_W-1]);
    sum_o = wide[DATA_W-1:0];
    if (ovf_o)
      sum_o = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
endmodule

// File: rtl/psum_accum.sv
// Read-modify-write accumulator in front of the PSUM buffer.
// Two-stage pipe: S1 issues the buffer read (data back after negedge),
// S2 adds and writes back (buffer writes at negedge). Back-to-back ops to
// the same row forward the S2 sum into S1's "old" value. A bulk clear drains
// the pipe, then zeroes every row, one per cycle.
// Ports:
//   clk_i, rst_n          clock / async active-low reset
//   clr_start_i/clr_busy_o bulk-clear request / busy
//   in_*                  op stream (valid/ready, addr, data, first, last)
//   buf_read_*/buf_write_* PSUM buffer ports
//   out_*                 final-sum pulse for ops marked last
//   sat_flag_o            sticky saturation indicator, cleared by a clear request
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int DATA_W = PSUM_DATA_W,
  parameter int ADDR_W = PSUM_ROWS_LOG2,
  parameter bit SAT_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_first_i,
  input  logic              in_last_i,
  output logic              buf_read_en_o,
  output logic [ADDR_W-1:0] buf_read_addr_o,
  input  logic [DATA_W-1:0] buf_read_data_i,
  output logic              buf_write_en_o,
  output logic [ADDR_W-1:0] buf_write_addr_o,
  output logic [DATA_W-1:0] buf_write_data_o,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              sat_flag_o
);
  localparam int STAGES = 2;

  psum_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [STAGES:1]   vld_pipe_q;
  logic [ADDR_W-1:0] s1_addr_q, s2_addr_q;
  logic [DATA_W-1:0] s1_data_q, s2_data_q, s2_old_q, old_d;
  logic              s1_first_q, s1_last_q, s2_first_q, s2_last_q;
  logic              sat_q, sat_d;
  logic              rdy_q;   // low only while in reset, so in_ready reads 0 then
  logic              accept, fwd, ovf;
  logic [DATA_W-1:0] add_a, sum;

  assign accept     = in_valid_i & in_ready_o;
  assign in_ready_o = rdy_q & (state_q == ST_IDLE) & ~clr_start_i;
  assign clr_busy_o = (state_q != ST_IDLE);

  // First op of a row ignores the stored value: add to zero.
  assign add_a = s2_first_q ? '0 : s2_old_q;

  psum_sat_add #(.DATA_W(DATA_W), .SAT_EN(SAT_EN)) u_add (
    .a_i   (add_a),
    .b_i   (s2_data_q),
    .sum_o (sum),
    .ovf_o (ovf)
  );

  // S1 read and S2 write hit the same negedge; the read would see stale data.
  assign fwd   = vld_pipe_q[1] & vld_pipe_q[2] & (s1_addr_q == s2_addr_q);
  assign old_d = fwd ? sum : buf_read_data_i;

  assign buf_read_en_o   = vld_pipe_q[1] & ~s1_first_q;
  assign buf_read_addr_o = s1_addr_q;

  always_comb begin
    buf_write_en_o   = vld_pipe_q[2];
    buf_write_addr_o = s2_addr_q;
    buf_write_data_o = sum;
    if (state_q == ST_CLEAR) begin
      buf_write_en_o   = 1'b1;
      buf_write_addr_o = cnt_q;
      buf_write_data_o = '0;
    end
  end

  assign out_valid_o = vld_pipe_q[2] & s2_last_q;
  assign out_addr_o  = s2_addr_q;
  assign out_data_o  = sum;
  assign sat_flag_o  = sat_q;

  // A saturating write-back in the same cycle as the clear request still counts.
  assign sat_d = ((clr_start_i && state_q == ST_IDLE) ? 1'b0 : sat_q) | (vld_pipe_q[2] & ovf);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (clr_start_i) state_d = ST_DRAIN;
      ST_DRAIN: if (vld_pipe_q == '0) begin
                  state_d = ST_CLEAR;
                  cnt_d   = '0;
                end
      ST_CLEAR: begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == '1) state_d = ST_IDLE;
                end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_old_q   <= '0;
      sat_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= {vld_pipe_q[1], accept};
      sat_q      <= sat_d;
      rdy_q      <= 1'b1;
      if (accept) begin
        s1_addr_q  <= in_addr_i;
        s1_data_q  <= in_data_i;
        s1_first_q <= in_first_i;
        s1_last_q  <= in_last_i;
      end
      if (vld_pipe_q[1]) begin
        s2_addr_q  <= s1_addr_q;
        s2_data_q  <= s1_data_q;
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        s2_old_q   <= old_d;
      end
    end
  end
endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;
  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        clr_start_i, clr_busy_o;
  logic        in_valid_i, in_ready_o, in_first_i, in_last_i;
  logic [7:0]  in_addr_i;
  logic [31:0] in_data_i;
  logic        buf_read_en_o, buf_write_en_o;
  logic [7:0]  buf_read_addr_o, buf_write_addr_o;
  logic [31:0] buf_read_data_i, buf_write_data_o;
  logic        out_valid_o, sat_flag_o;
  logic [7:0]  out_addr_o;
  logic [31:0] out_data_o;

  psum_accum #(.DATA_W(32), .ADDR_W(8), .SAT_EN(1'b1)) dut (
    .clk_i, .rst_n, .clr_start_i, .clr_busy_o,
    .in_valid_i, .in_ready_o, .in_addr_i, .in_data_i, .in_first_i, .in_last_i,
    .buf_read_en_o, .buf_read_addr_o, .buf_read_data_i,
    .buf_write_en_o, .buf_write_addr_o, .buf_write_data_o,
    .out_valid_o, .out_addr_o, .out_data_o, .sat_flag_o
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0, cyc = 0, rdy_bad = 0;
  bit cap_en = 1'b0;

  typedef struct { logic [7:0] a; logic [31:0] d; int c; } ev_t;
  ev_t outq[$];
  ev_t wrq[$];

  // Negedge-acting buffer model.
  logic [31:0] mem [256];
  logic [31:0] rd_q = '0;
  assign buf_read_data_i = rd_q;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    ev_t e;
    if (buf_read_en_o)  rd_q <= mem[buf_read_addr_o];
    if (buf_write_en_o) mem[buf_write_addr_o] <= buf_write_data_o;
    if (rst_n && out_valid_o) begin
      e.a = out_addr_o; e.d = out_data_o; e.c = cyc;
      outq.push_back(e);
    end
    if (cap_en && buf_write_en_o) begin
      e.a = buf_write_addr_o; e.d = buf_write_data_o; e.c = cyc;
      wrq.push_back(e);
    end
    if (cap_en && clr_busy_o && in_ready_o) rdy_bad <= rdy_bad + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic op(input logic [7:0] a, input logic [31:0] d, input logic f, input logic l);
    in_valid_i = 1'b1; in_addr_i = a; in_data_i = d; in_first_i = f; in_last_i = l;
    tick();
    in_valid_i = 1'b0; in_first_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && clr_busy_o; i++) tick();
    chk(tag, clr_busy_o, 0);
  endtask

  task automatic do_clear();
    clr_start_i = 1'b1; tick(); clr_start_i = 1'b0;
    wait_idle("clear_done");
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; clr_start_i = 0; in_valid_i = 0; in_addr_i = 0; in_data_i = 0;
    in_first_i = 0; in_last_i = 0;
    #12;
    chk("rst_ctl", {clr_busy_o, in_ready_o, buf_read_en_o, buf_write_en_o, out_valid_o, sat_flag_o}, 0);
    chk("rst_data", {buf_write_addr_o, buf_write_data_o, out_data_o}, 0);
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", in_ready_o, 1);
    do_clear();

    // Spaced ops to row 3: 5 (first), +7, -2 (last) -> 10
    outq.delete();
    op(3, 32'd5, 1, 0); tick(); tick();
    op(3, 32'd7, 0, 0); tick(); tick();
    op(3, 32'hFFFF_FFFE, 0, 1); tick(); tick(); tick();
    chk("sp_cnt", outq.size(), 1);
    if (outq.size() > 0) begin
      chk("sp_addr", outq[0].a, 3);
      chk("sp_data", outq[0].d, 10);
    end
    chk("sp_row3", mem[3], 10);

    // Back-to-back same row: forwarding gives 4
    outq.delete();
    op(9, 1, 1, 0); op(9, 1, 0, 0); op(9, 1, 0, 0); op(9, 1, 0, 1);
    tick(); tick(); tick();
    chk("fwd_cnt", outq.size(), 1);
    if (outq.size() > 0) chk("fwd_data", outq[0].d, 4);
    chk("fwd_row9", mem[9], 4);

    // Interleaved rows 1,2,1,2 -> (1,40) then (2,60) on consecutive cycles
    outq.delete();
    op(1, 10, 1, 0); op(2, 20, 1, 0); op(1, 30, 0, 1); op(2, 40, 0, 1);
    tick(); tick(); tick();
    chk("il_cnt", outq.size(), 2);
    if (outq.size() > 1) begin
      chk("il_o0", {outq[0].a, outq[0].d}, {8'd1, 32'd40});
      chk("il_o1", {outq[1].a, outq[1].d}, {8'd2, 32'd60});
      chk("il_gap", outq[1].c - outq[0].c, 1);
    end
    chk("sat_clean", sat_flag_o, 0);

    // Positive and negative saturation
    outq.delete();
    op(0, 32'h7FFF_FFF0, 1, 0); tick(); tick();
    op(0, 32'h0000_0100, 0, 1); tick(); tick(); tick();
    op(5, 32'h8000_0010, 1, 0); tick(); tick();
    op(5, 32'hFFFF_FFE0, 0, 1); tick(); tick(); tick();
    chk("sat_cnt", outq.size(), 2);
    if (outq.size() > 1) begin
      chk("sat_pos", outq[0].d, 32'h7FFF_FFFF);
      chk("sat_neg", outq[1].d, 32'h8000_0000);
    end
    chk("sat_flag", sat_flag_o, 1);
    clr_start_i = 1'b1; tick(); clr_start_i = 1'b0;
    chk("sat_cleared", sat_flag_o, 0);
    wait_idle("sat_clr_done");

    // Clear with two ops in flight, competing op and a repeat request
    outq.delete(); wrq.delete(); cap_en = 1'b1;
    op(20, 5, 1, 0); op(21, 6, 1, 0);
    clr_start_i = 1'b1; in_valid_i = 1'b1; in_addr_i = 30; in_data_i = 77;
    in_first_i = 1'b1; in_last_i = 1'b1;
    #1;
    chk("clr_vs_op_rdy", in_ready_o, 0);
    chk("busy_pre", clr_busy_o, 0);
    tick();
    clr_start_i = 1'b0; in_valid_i = 1'b0; in_first_i = 0; in_last_i = 0;
    chk("busy_post", clr_busy_o, 1);
    for (int i = 0; i < 60; i++) tick();
    clr_start_i = 1'b1; tick(); clr_start_i = 1'b0;
    wait_idle("clr2_done");
    tick();
    cap_en = 1'b0;
    chk("clr_wr_cnt", wrq.size(), 258);
    bad = 0;
    if (wrq.size() < 2 || wrq[0].a != 20 || wrq[0].d != 5 || wrq[1].a != 21 || wrq[1].d != 6) bad++;
    for (int i = 0; i < 256; i++)
      if (i + 2 >= wrq.size() || wrq[i+2].a != i[7:0] || wrq[i+2].d != 0) bad++;
    chk("clr_seq", bad, 0);
    chk("clr_rdy_low", rdy_bad, 0);
    chk("clr_no_out", outq.size(), 0);
    op(20, 0, 0, 1); op(77, 0, 0, 1); tick(); tick(); tick();
    chk("rd0_cnt", outq.size(), 2);
    if (outq.size() > 1) begin
      chk("rd0_r20", {outq[0].a, outq[0].d}, {8'd20, 32'd0});
      chk("rd0_r77", {outq[1].a, outq[1].d}, {8'd77, 32'd0});
    end

    // Reset in the middle of a clear (row 100)
    clr_start_i = 1'b1; tick(); clr_start_i = 1'b0;
    bad = 1;
    for (int i = 0; i < 400; i++) begin
      if (buf_write_en_o && clr_busy_o && buf_write_addr_o == 100) begin bad = 0; break; end
      tick();
    end
    chk("reach_row100", bad, 0);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_ctl", {clr_busy_o, in_ready_o, buf_read_en_o, buf_write_en_o, out_valid_o, sat_flag_o}, 0);
    chk("mid_rst_data", {buf_write_addr_o, buf_write_data_o, out_addr_o, out_data_o}, 0);
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_idle", clr_busy_o, 0);
    chk("post_rst_rdy", in_ready_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
